// File: rtl/fsl_ring_tap.sv
// fsl_ring_tap: one node on the 32-bit FSL ring.
// Words pass through with one register stage. DIN frames can be captured into
// a local RX FIFO. Result vectors from a TX FIFO can be inserted into free or
// just-captured slots.
// Optional build macro: FSL_RING_TAP_STATS_EN enables the stat_* counters.
// When the macro is not defined, stat_* are tied to zero.
module fsl_ring_tap #(
  parameter int CORE        = 0,
  parameter int FRAME_WORDS = 5,
  parameter int RX_DEPTH    = 4,
  parameter int TX_DEPTH    = 4,
  localparam int VEC_W      = 32 * FRAME_WORDS
) (
  input  logic             fsl_clk,
  input  logic             fsl_rst_i,
  input  logic [31:0]      fsl_data_i,
  input  logic             fsl_valid_i,
  output logic             fsl_rst_o,
  output logic [31:0]      fsl_data_o,
  output logic             fsl_valid_o,
  output logic [VEC_W-1:0] vec_dout,
  input  logic             vec_rd,
  output logic             vec_empty,
  input  logic [VEC_W-1:0] vec_din,
  input  logic             vec_wr,
  output logic             vec_full,
  output logic [31:0]      stat_capture,
  output logic [31:0]      stat_insert,
  output logic [31:0]      stat_drop
);

  localparam int W_W  = $clog2(FRAME_WORDS);
  localparam int RA_W = $clog2(RX_DEPTH);
  localparam int TA_W = $clog2(TX_DEPTH);
  // Phase offset so that node CORE sees headers at w=0, given 1 cycle per upstream node.
  localparam int PHASE = (FRAME_WORDS - (CORE % FRAME_WORDS)) % FRAME_WORDS;
  localparam logic [W_W-1:0] W_RST  = W_W'(PHASE);
  localparam logic [W_W-1:0] W_LAST = W_W'(FRAME_WORDS - 1);

  logic [W_W-1:0]   w_q, w_d;
  logic             cap_q, cap_d;
  logic             ins_q, ins_d;
  logic             cap_ok_q, cap_ok_d;
  logic [VEC_W-1:0] cap_sh_q, cap_sh_d;
  logic [VEC_W-1:0] ins_sh_q, ins_sh_d;
  logic [31:0]      data_o_q, data_o_d;
  logic             valid_o_q, valid_o_d;
  logic             rst_o_q;

  logic [VEC_W-1:0] rx_mem [RX_DEPTH];
  logic [RA_W-1:0]  rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RA_W:0]    rx_cnt_q, rx_cnt_d;
  logic [VEC_W-1:0] tx_mem [TX_DEPTH];
  logic [TA_W-1:0]  tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TA_W:0]    tx_cnt_q, tx_cnt_d;

  logic             slot0, last, rx_space, hdr_din;
  logic             cap_now, ins_now, cap_act, ins_act, cap_ok;
  logic [VEC_W-1:0] cap_frame, tx_head;
  logic             rx_push, rx_pop, tx_push, tx_pop;

  assign slot0     = (w_q == '0);
  assign last      = (w_q == W_LAST);
  assign rx_space  = (rx_cnt_q < (RA_W + 1)'(RX_DEPTH));
  assign hdr_din   = fsl_valid_i && !fsl_data_i[31];
  assign tx_head   = tx_mem[tx_rp_q];
  assign cap_frame = {cap_sh_q[VEC_W-33:0], fsl_data_i};

  assign vec_dout    = rx_mem[rx_rp_q];
  assign vec_empty   = (rx_cnt_q == '0);
  assign vec_full    = (tx_cnt_q == (TA_W + 1)'(TX_DEPTH));
  assign fsl_data_o  = data_o_q;
  assign fsl_valid_o = valid_o_q;
  assign fsl_rst_o   = rst_o_q;

  // Slot classification at w=0; the decisions are then held for the rest of the slot.
  always_comb begin
    cap_now = slot0 && hdr_din && rx_space;
    ins_now = slot0 && (tx_cnt_q != '0) && (!fsl_valid_i || cap_now);
    cap_act = slot0 ? cap_now : cap_q;
    ins_act = slot0 ? ins_now : ins_q;
    cap_d   = cap_act;
    ins_d   = ins_act;
    w_d     = last ? '0 : w_q + W_W'(1);
  end

  // Capture shift register, plus the tracking of whether every word was valid.
  always_comb begin
    cap_ok   = (slot0 ? 1'b1 : cap_ok_q) & fsl_valid_i;
    cap_sh_d = cap_sh_q;
    cap_ok_d = cap_ok_q;
    if (cap_act) begin
      cap_sh_d = cap_frame;
      cap_ok_d = cap_ok;
    end
    rx_push = cap_act && last && cap_ok;
    rx_pop  = vec_rd && !vec_empty;
    tx_push = vec_wr && !vec_full;
    tx_pop  = ins_now;
  end

  // Output word selection: inserted result, blanked slot, or pass-through.
  always_comb begin
    ins_sh_d  = ins_sh_q;
    data_o_d  = fsl_data_i;
    valid_o_d = fsl_valid_i;
    if (ins_now) begin
      ins_sh_d  = {tx_head[VEC_W-33:0], 32'h0};
      data_o_d  = tx_head[VEC_W-1 -: 32] | 32'h8000_0000;
      valid_o_d = 1'b1;
    end else if (ins_act) begin
      ins_sh_d  = {ins_sh_q[VEC_W-33:0], 32'h0};
      data_o_d  = ins_sh_q[VEC_W-1 -: 32];
      valid_o_d = 1'b1;
    end else if (cap_act) begin
      data_o_d  = 32'h0;
      valid_o_d = 1'b0;
    end
  end

  // FIFO pointer and occupancy updates. A simultaneous push and pop leaves the count unchanged.
  always_comb begin
    rx_wp_d  = rx_push ? rx_wp_q + RA_W'(1) : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + RA_W'(1) : rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    unique case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + (RA_W + 1)'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - (RA_W + 1)'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
    tx_wp_d  = tx_push ? tx_wp_q + TA_W'(1) : tx_wp_q;
    tx_rp_d  = tx_pop  ? tx_rp_q + TA_W'(1) : tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    unique case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + (TA_W + 1)'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - (TA_W + 1)'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  // Control state, ring output register and reset forwarding.
  always_ff @(posedge fsl_clk or posedge fsl_rst_i) begin
    if (fsl_rst_i) begin
      w_q       <= W_RST;
      cap_q     <= 1'b0;
      ins_q     <= 1'b0;
      cap_ok_q  <= 1'b0;
      cap_sh_q  <= '0;
      ins_sh_q  <= '0;
      data_o_q  <= 32'h0;
      valid_o_q <= 1'b0;
      rst_o_q   <= 1'b1;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_cnt_q  <= '0;
    end else begin
      w_q       <= w_d;
      cap_q     <= cap_d;
      ins_q     <= ins_d;
      cap_ok_q  <= cap_ok_d;
      cap_sh_q  <= cap_sh_d;
      ins_sh_q  <= ins_sh_d;
      data_o_q  <= data_o_d;
      valid_o_q <= valid_o_d;
      rst_o_q   <= 1'b0;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      tx_cnt_q  <= tx_cnt_d;
    end
  end

  // FIFO storage. The storage itself needs no reset because the pointers define what is valid.
  always_ff @(posedge fsl_clk) begin
    if (rx_push) rx_mem[rx_wp_q] <= cap_frame;
    if (tx_push) tx_mem[tx_wp_q] <= vec_din;
  end

`ifdef FSL_RING_TAP_STATS_EN
  logic        drop;
  logic [31:0] stat_capture_q, stat_capture_d;
  logic [31:0] stat_insert_q, stat_insert_d;
  logic [31:0] stat_drop_q, stat_drop_d;

  // Free-running event counters. They wrap at 2^32.
  always_comb begin
    drop           = cap_act && last && !cap_ok;
    stat_capture_d = stat_capture_q + 32'(rx_push);
    stat_insert_d  = stat_insert_q + 32'(tx_pop);
    stat_drop_d    = stat_drop_q + 32'(drop);
  end

  // Counter registers.
  always_ff @(posedge fsl_clk or posedge fsl_rst_i) begin
    if (fsl_rst_i) begin
      stat_capture_q <= '0;
      stat_insert_q  <= '0;
      stat_drop_q    <= '0;
    end else begin
      stat_capture_q <= stat_capture_d;
      stat_insert_q  <= stat_insert_d;
      stat_drop_q    <= stat_drop_d;
    end
  end

  assign stat_capture = stat_capture_q;
  assign stat_insert  = stat_insert_q;
  assign stat_drop    = stat_drop_q;
`else
  assign stat_capture = 32'h0;
  assign stat_insert  = 32'h0;
  assign stat_drop    = 32'h0;
`endif

endmodule

// File: tb/tb_fsl_ring_tap.sv
// Directed bench for fsl_ring_tap: node CORE=0 for the main traffic tests,
// and node CORE=3 for the slot-phase check.
module tb_fsl_ring_tap;
  localparam int FW = 5;
  localparam int VW = 32 * FW;
`ifdef FSL_RING_TAP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, vin, rsto, vout, vec_rd, vec_empty, vec_wr, vec_full;
  logic [31:0]   din, dout, st_cap, st_ins, st_drop;
  logic [VW-1:0] vec_dout, vec_din;

  logic          rst3, vin3, rsto3, vout3, vec_empty3, vec_full3;
  logic [31:0]   din3, dout3, st_cap3, st_ins3, st_drop3;
  logic [VW-1:0] vec_dout3;

  fsl_ring_tap #(.CORE(0), .FRAME_WORDS(FW), .RX_DEPTH(4), .TX_DEPTH(4)) dut (
    .fsl_clk(clk), .fsl_rst_i(rst), .fsl_data_i(din), .fsl_valid_i(vin),
    .fsl_rst_o(rsto), .fsl_data_o(dout), .fsl_valid_o(vout),
    .vec_dout(vec_dout), .vec_rd(vec_rd), .vec_empty(vec_empty),
    .vec_din(vec_din), .vec_wr(vec_wr), .vec_full(vec_full),
    .stat_capture(st_cap), .stat_insert(st_ins), .stat_drop(st_drop));

  fsl_ring_tap #(.CORE(3), .FRAME_WORDS(FW), .RX_DEPTH(4), .TX_DEPTH(4)) dut3 (
    .fsl_clk(clk), .fsl_rst_i(rst3), .fsl_data_i(din3), .fsl_valid_i(vin3),
    .fsl_rst_o(rsto3), .fsl_data_o(dout3), .fsl_valid_o(vout3),
    .vec_dout(vec_dout3), .vec_rd(1'b0), .vec_empty(vec_empty3),
    .vec_din('0), .vec_wr(1'b0), .vec_full(vec_full3),
    .stat_capture(st_cap3), .stat_insert(st_ins3), .stat_drop(st_drop3));

  int vectors = 0;
  int miscompares = 0;
  int ph = 0;
  int exp_cap = 0, exp_ins = 0, exp_drop = 0;
  logic [VW-1:0] got_d;
  logic [4:0]    got_v;

  // One clock: inputs are driven at the negedge, and outputs are read back at the next negedge.
  task automatic tick();
    @(posedge clk);
    ph = (ph + 1) % FW;
    @(negedge clk);
  endtask

  task automatic idle_to_slot0();
    din = 32'h0; vin = 1'b0;
    while (ph != 0) tick();
  endtask

  // Drive one slot starting at w=0. Record the 5 output words (word 0 at the MSB end) and their valids.
  task automatic send(input logic [VW-1:0] f, input logic [4:0] v, input bit rd_last);
    idle_to_slot0();
    for (int i = 0; i < FW; i++) begin
      din = f[VW-1-32*i -: 32];
      vin = v[i];
      vec_rd = rd_last && (i == FW - 1);
      tick();
      got_d[VW-1-32*i -: 32] = dout;
      got_v[i] = vout;
    end
    din = 32'h0; vin = 1'b0; vec_rd = 1'b0;
  endtask

  task automatic push_tx(input logic [VW-1:0] r);
    vec_din = r; vec_wr = 1'b1;
    tick();
    vec_wr = 1'b0;
  endtask

  task automatic pop_rx();
    vec_rd = 1'b1;
    tick();
    vec_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    vectors++; if (rsto !== 1'b1) begin miscompares++; $display("FAIL reset_rst_o got %b want 1", rsto); end
    vectors++; if (dout !== 32'h0 || vout !== 1'b0) begin miscompares++; $display("FAIL reset_out got %h/%b want 0/0", dout, vout); end
    vectors++; if (vec_empty !== 1'b1 || vec_full !== 1'b0) begin miscompares++; $display("FAIL reset_fifo got empty=%b full=%b want 1/0", vec_empty, vec_full); end
    vectors++; if ({st_cap, st_ins, st_drop} !== 96'h0) begin miscompares++; $display("FAIL reset_stats got %h %h %h want 0", st_cap, st_ins, st_drop); end
    rst = 1'b0; ph = 0;
    tick();
    vectors++; if (rsto !== 1'b0) begin miscompares++; $display("FAIL rst_o_release got %b want 0", rsto); end
  endtask

  task automatic test_capture();
    logic [VW-1:0] f;
    f = 160'h00000001_00000002_00000003_00000004_00000005;
    send(f, 5'b11111, 1'b0);
    exp_cap++;
    vectors++; if (got_v !== 5'b00000) begin miscompares++; $display("FAIL capture_valid_o got %b want 00000", got_v); end
    vectors++; if (vec_empty !== 1'b0) begin miscompares++; $display("FAIL capture_empty got %b want 0", vec_empty); end
    vectors++; if (vec_dout !== f) begin miscompares++; $display("FAIL capture_dout got %h want %h", vec_dout, f); end
    pop_rx();
    vectors++; if (vec_empty !== 1'b1) begin miscompares++; $display("FAIL capture_pop got %b want 1", vec_empty); end
  endtask

  task automatic test_insert();
    push_tx(160'hAB);
    vectors++; if (vec_full !== 1'b0) begin miscompares++; $display("FAIL insert_full got %b want 0", vec_full); end
    send('0, 5'b00000, 1'b0);
    exp_ins++;
    vectors++; if (got_d !== 160'h80000000_00000000_00000000_00000000_000000AB) begin miscompares++; $display("FAIL insert_data got %h want 80000000_..._000000ab", got_d); end
    vectors++; if (got_v !== 5'b11111) begin miscompares++; $display("FAIL insert_valid got %b want 11111", got_v); end
    vectors++; if (st_ins !== (STATS ? 32'(exp_ins) : 32'h0)) begin miscompares++; $display("FAIL insert_stat got %0d want %0d", st_ins, STATS ? exp_ins : 0); end
  endtask

  task automatic test_dout_pass();
    logic [VW-1:0] f;
    f = 160'h80000007_DEADBEEF_01234567_89ABCDEF_FFFFFFFF;
    send(f, 5'b11111, 1'b0);
    vectors++; if (got_d !== f || got_v !== 5'b11111) begin miscompares++; $display("FAIL dout_pass got %h/%b want %h/11111", got_d, got_v, f); end
    vectors++; if (vec_empty !== 1'b1) begin miscompares++; $display("FAIL dout_not_captured got empty=%b want 1", vec_empty); end
  endtask

  task automatic test_drop();
    send(160'h00000009_0000000A_0000000B_0000000C_0000000D, 5'b11011, 1'b0);
    exp_drop++;
    vectors++; if (vec_empty !== 1'b1) begin miscompares++; $display("FAIL drop_empty got %b want 1", vec_empty); end
    vectors++; if (got_v !== 5'b00000) begin miscompares++; $display("FAIL drop_valid got %b want 00000", got_v); end
    vectors++; if (st_drop !== (STATS ? 32'(exp_drop) : 32'h0)) begin miscompares++; $display("FAIL drop_stat got %0d want %0d", st_drop, STATS ? exp_drop : 0); end
  endtask

  task automatic test_rx_full();
    logic [VW-1:0] f, fx;
    for (int k = 0; k < 4; k++) begin
      f = {32'h100 + 32'(k), 32'h200 + 32'(k), 32'h300 + 32'(k), 32'h400 + 32'(k), 32'h500 + 32'(k)};
      send(f, 5'b11111, 1'b0);
    end
    exp_cap += 4;
    fx = 160'h0000FFFF_11112222_33334444_55556666_77778888;
    send(fx, 5'b11111, 1'b0);
    vectors++; if (got_d !== fx || got_v !== 5'b11111) begin miscompares++; $display("FAIL rx_full_pass got %h/%b want %h/11111", got_d, got_v, fx); end
    for (int k = 0; k < 4; k++) begin
      f = {32'h100 + 32'(k), 32'h200 + 32'(k), 32'h300 + 32'(k), 32'h400 + 32'(k), 32'h500 + 32'(k)};
      vectors++; if (vec_dout !== f || vec_empty !== 1'b0) begin miscompares++; $display("FAIL rx_full_order%0d got %h want %h", k, vec_dout, f); end
      pop_rx();
    end
    vectors++; if (vec_empty !== 1'b1) begin miscompares++; $display("FAIL rx_full_count got empty=%b want 1", vec_empty); end
  endtask

  task automatic test_cap_insert();
    logic [VW-1:0] d;
    d = 160'h00000A00_00000A01_00000A02_00000A03_00000A04;
    push_tx(160'h11111111_22222222_33333333_44444444_55555555);
    send(d, 5'b11111, 1'b0);
    exp_cap++; exp_ins++;
    vectors++; if (got_d !== 160'h91111111_22222222_33333333_44444444_55555555 || got_v !== 5'b11111) begin miscompares++; $display("FAIL cap_insert_out got %h/%b want 91111111_22222222_33333333_44444444_55555555/11111", got_d, got_v); end
    vectors++; if (vec_dout !== d || vec_empty !== 1'b0) begin miscompares++; $display("FAIL cap_insert_rx got %h want %h", vec_dout, d); end
    vectors++; if (st_cap !== (STATS ? 32'(exp_cap) : 32'h0) || st_ins !== (STATS ? 32'(exp_ins) : 32'h0)) begin miscompares++; $display("FAIL cap_insert_stats got %0d/%0d want %0d/%0d", st_cap, st_ins, STATS ? exp_cap : 0, STATS ? exp_ins : 0); end
    pop_rx();
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] a, b, r1, r2;
    a  = 160'h00000021_00000022_00000023_00000024_00000025;
    b  = 160'h00000031_00000032_00000033_00000034_00000035;
    r1 = 160'h00000041_00000042_00000043_00000044_00000045;
    r2 = 160'h70000051_00000052_00000053_00000054_00000055;
    send(a, 5'b11111, 1'b0);
    send(b, 5'b11111, 1'b1);
    exp_cap += 2;
    vectors++; if (vec_dout !== b || vec_empty !== 1'b0) begin miscompares++; $display("FAIL b2b_rd_wr got %h empty=%b want %h empty=0", vec_dout, vec_empty, b); end
    pop_rx();
    vectors++; if (vec_empty !== 1'b1) begin miscompares++; $display("FAIL b2b_rd_wr_count got empty=%b want 1", vec_empty); end
    push_tx(r1);
    idle_to_slot0();
    for (int i = 0; i < FW; i++) begin
      vec_din = r2; vec_wr = (i == 0);
      tick();
      got_d[VW-1-32*i -: 32] = dout;
      got_v[i] = vout;
    end
    vec_wr = 1'b0;
    vectors++; if (got_d !== (r1 | {1'b1, 159'h0}) || got_v !== 5'b11111) begin miscompares++; $display("FAIL b2b_pop_push1 got %h/%b", got_d, got_v); end
    send('0, 5'b00000, 1'b0);
    exp_ins += 2;
    vectors++; if (got_d !== 160'hF0000051_00000052_00000053_00000054_00000055 || got_v !== 5'b11111) begin miscompares++; $display("FAIL b2b_pop_push2 got %h/%b", got_d, got_v); end
  endtask

  task automatic test_phase();
    logic [VW-1:0] d;
    d = 160'h00000003_00000013_00000023_00000033_00000043;
    rst3 = 1'b0;
    tick();
    vectors++; if (rsto3 !== 1'b0) begin miscompares++; $display("FAIL phase_rst_o got %b want 0", rsto3); end
    tick(); tick();
    for (int i = 0; i < FW; i++) begin
      din3 = d[VW-1-32*i -: 32]; vin3 = 1'b1;
      tick();
      got_v[i] = vout3;
    end
    din3 = 32'h0; vin3 = 1'b0;
    vectors++; if (got_v !== 5'b00000) begin miscompares++; $display("FAIL phase_valid got %b want 00000", got_v); end
    vectors++; if (vec_dout3 !== d || vec_empty3 !== 1'b0) begin miscompares++; $display("FAIL phase_capture got %h empty=%b want %h", vec_dout3, vec_empty3, d); end
  endtask

  task automatic test_reset_mid_insert();
    push_tx(160'h0000000C_0000000D_0000000E_0000000F_00000010);
    idle_to_slot0();
    tick(); tick();
    vectors++; if (vout !== 1'b1 || dout !== 32'h0000000D) begin miscompares++; $display("FAIL mid_insert_pre got %h/%b want 0000000d/1", dout, vout); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (vout !== 1'b0 || dout !== 32'h0 || rsto !== 1'b1) begin miscompares++; $display("FAIL mid_insert_async got %h/%b rst_o=%b want 0/0/1", dout, vout, rsto); end
    vectors++; if (vec_empty !== 1'b1 || vec_full !== 1'b0 || st_ins !== 32'h0) begin miscompares++; $display("FAIL mid_insert_state got empty=%b full=%b ins=%0d", vec_empty, vec_full, st_ins); end
    @(negedge clk);
    rst = 1'b0; ph = 0;
    send('0, 5'b00000, 1'b0);
    vectors++; if (got_v !== 5'b00000) begin miscompares++; $display("FAIL mid_insert_lost got %b want 00000", got_v); end
  endtask

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    din = '0; vin = 1'b0; vec_rd = 1'b0; vec_wr = 1'b0; vec_din = '0;
    din3 = '0; vin3 = 1'b0;
    test_reset();
    test_capture();
    test_insert();
    test_dout_pass();
    test_drop();
    test_rx_full();
    test_cap_insert();
    test_back_to_back();
    test_phase();
    test_reset_mid_insert();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
